// File: rtl/multicycle_sequencer_pkg.sv
// Shared definitions for the RISC-KGP multi-cycle sequencer: state encoding,
// default parameter values and the instruction opcode map.
package multicycle_sequencer_pkg;

    // Debug-visible state encoding; the numeric values are part of the interface.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_FAULT  = 3'd7
    } seq_state_e;

    localparam int           DEF_CNT_W       = 32;
    localparam int           DEF_MEM_TIMEOUT = 15;
    localparam logic [4:0]   DEF_HALT_OPCODE = 5'd31;

    // Opcode map, IR[31:27]
    localparam logic [4:0] OP_ALU   = 5'd0;
    localparam logic [4:0] OP_ADDI  = 5'd1;
    localparam logic [4:0] OP_LW    = 5'd2;
    localparam logic [4:0] OP_SW    = 5'd3;
    localparam logic [4:0] OP_COMPI = 5'd4;
    localparam logic [4:0] OP_SHIFT = 5'd5;
    localparam logic [4:0] OP_BR    = 5'd6;
    localparam logic [4:0] OP_BRC   = 5'd7;
    localparam logic [4:0] OP_JR    = 5'd8;
    localparam logic [4:0] OP_BAL   = 5'd9;

    // States in which the sequencer is waiting on a memory acknowledge.
    function automatic logic is_wait_state(input seq_state_e s);
        return (s == ST_FETCH) || (s == ST_MEM);
    endfunction

endpackage

// File: rtl/multicycle_sequencer_wait_timer.sv
// Memory-acknowledge wait timer. Counts cycles spent waiting without an
// acknowledge; o_expired is high once MEM_TIMEOUT such cycles have elapsed.
module multicycle_sequencer_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_tick,
    output logic o_expired
);

    localparam int TW = $clog2(MEM_TIMEOUT + 1);

    logic [TW-1:0] r_count;

    assign o_expired = (r_count == TW'(MEM_TIMEOUT));

    // Count unacknowledged wait cycles; saturate at the limit, restart on clear.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_tick && !o_expired) begin
            r_count <= r_count + TW'(1);
        end
    end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle sequencer for the RISC-KGP datapath. Steps each instruction
// through FETCH/DECODE/EXEC/MEM/WB, gates IR load, PC commit, memory requests
// and register-file writes, counts retirements and supports halt/resume.
// A memory that fails to acknowledge within MEM_TIMEOUT wait cycles, or a
// decode asking for both read and write, parks the sequencer in FAULT until reset.
// Handshake: a request is held high every cycle until the matching ack is
// sampled high on a rising edge; the ack cycle itself completes the access.
module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
#(
    parameter int         CNT_W       = DEF_CNT_W,
    parameter int         MEM_TIMEOUT = DEF_MEM_TIMEOUT,
    parameter logic [4:0] HALT_OPCODE = DEF_HALT_OPCODE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             halt_req,
    input  logic [4:0]       opCode,
    input  logic             dec_mem_read,
    input  logic             dec_mem_write,
    input  logic             dec_reg_write,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    output logic             imem_req,
    output logic             ir_load,
    output logic             dmem_rd_req,
    output logic             dmem_wr_req,
    output logic             rf_we,
    output logic             pc_write,
    output logic             busy,
    output logic             fault,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instr_count
);

    seq_state_e       r_state;
    logic [CNT_W-1:0] r_instr_count;
    logic             r_halt_pend;

    logic       w_wait_state;
    logic       w_ack;
    logic       w_expired;
    logic       w_busy;
    logic       w_retire;
    seq_state_e w_after_retire;

    assign w_wait_state = is_wait_state(r_state);
    assign w_ack        = (r_state == ST_FETCH) ? imem_ack : dmem_ack;
    assign w_busy       = (r_state == ST_FETCH) || (r_state == ST_DECODE) ||
                          (r_state == ST_EXEC)  || (r_state == ST_MEM)    ||
                          (r_state == ST_WB);

    // Retirement: WB, a no-memory no-writeback instruction in EXEC, or a store on its ack.
    assign w_retire = (r_state == ST_WB) ||
                      ((r_state == ST_EXEC) && !dec_mem_read && !dec_mem_write && !dec_reg_write) ||
                      ((r_state == ST_MEM) && dmem_ack && dec_mem_write && !dec_mem_read);

    assign w_after_retire = (halt_req || r_halt_pend) ? ST_HALT : ST_FETCH;

    multicycle_sequencer_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .i_clk     (clk),
        .i_rst_n   (rst),
        .i_clear   (!w_wait_state || w_ack),
        .i_tick    (w_wait_state && !w_ack),
        .o_expired (w_expired)
    );

    // Output decode from current state and the handshake/decoder inputs.
    always_comb begin
        imem_req    = (r_state == ST_FETCH);
        ir_load     = (r_state == ST_FETCH) && imem_ack;
        dmem_rd_req = (r_state == ST_MEM) && dec_mem_read;
        dmem_wr_req = (r_state == ST_MEM) && dec_mem_write;
        rf_we       = (r_state == ST_WB);
        pc_write    = w_retire;
        busy        = w_busy;
        fault       = (r_state == ST_FAULT);
    end

    assign state       = r_state;
    assign instr_count = r_instr_count;

    // Sequencer FSM, retired-instruction counter and pending-halt flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= ST_IDLE;
            r_instr_count <= '0;
            r_halt_pend   <= 1'b0;
        end else begin
            if (w_retire) begin
                r_instr_count <= r_instr_count + CNT_W'(1);
            end
            // A halt request seen mid-instruction is remembered until it retires.
            if (w_retire || !w_busy) begin
                r_halt_pend <= 1'b0;
            end else if (halt_req) begin
                r_halt_pend <= 1'b1;
            end

            unique case (r_state)
                ST_IDLE: begin
                    if (start) r_state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (imem_ack)       r_state <= ST_DECODE;
                    else if (w_expired) r_state <= ST_FAULT;
                end
                ST_DECODE: begin
                    r_state <= (opCode == HALT_OPCODE) ? ST_HALT : ST_EXEC;
                end
                ST_EXEC: begin
                    if (dec_mem_read && dec_mem_write)      r_state <= ST_FAULT;
                    else if (dec_mem_read || dec_mem_write) r_state <= ST_MEM;
                    else if (dec_reg_write)                 r_state <= ST_WB;
                    else                                    r_state <= w_after_retire;
                end
                ST_MEM: begin
                    if (dmem_ack)       r_state <= dec_mem_read ? ST_WB : w_after_retire;
                    else if (w_expired) r_state <= ST_FAULT;
                end
                ST_WB: begin
                    r_state <= w_after_retire;
                end
                ST_HALT: begin
                    if (start) r_state <= ST_FETCH;
                end
                ST_FAULT: begin
                    r_state <= ST_FAULT;
                end
                default: begin
                    r_state <= ST_FAULT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: a per-cycle vector table for the
// basic instruction flows, then hand-written sequences for waits, timeout,
// halt/resume, faults, asynchronous reset and counter wrap.
module tb_multicycle_sequencer;

    localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3,
                            S_MEM  = 3'd4, S_WB    = 3'd5, S_HALT   = 3'd6, S_FAULT = 3'd7;

    // Flags: {imem_req, ir_load, dmem_rd_req, dmem_wr_req, rf_we, pc_write, busy, fault}
    localparam logic [7:0] O_NONE = 8'b0000_0000;
    localparam logic [7:0] O_FW   = 8'b1000_0010;
    localparam logic [7:0] O_FA   = 8'b1100_0010;
    localparam logic [7:0] O_BSY  = 8'b0000_0010;
    localparam logic [7:0] O_WB   = 8'b0000_1110;
    localparam logic [7:0] O_PCW  = 8'b0000_0110;
    localparam logic [7:0] O_MRD  = 8'b0010_0010;
    localparam logic [7:0] O_MWR  = 8'b0001_0010;
    localparam logic [7:0] O_MWRA = 8'b0001_0110;
    localparam logic [7:0] O_FLT  = 8'b0000_0001;

    typedef struct {
        logic        st;
        logic        hr;
        logic [4:0]  op;
        logic        rd;
        logic        wr;
        logic        rw;
        logic        ia;
        logic        da;
        logic [2:0]  es;
        logic [7:0]  eo;
        logic [31:0] ec;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start, halt_req, rd, wr, rw, ia, da;
    logic [4:0] op;

    logic        imem_req, ir_load, dmem_rd_req, dmem_wr_req, rf_we, pc_write, busy, fault;
    logic [2:0]  state;
    logic [31:0] instr_count;
    logic        imem_req4, ir_load4, dmem_rd_req4, dmem_wr_req4, rf_we4, pc_write4, busy4, fault4;
    logic [2:0]  state4;
    logic [3:0]  instr_count4;

    multicycle_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .halt_req(halt_req), .opCode(op),
        .dec_mem_read(rd), .dec_mem_write(wr), .dec_reg_write(rw),
        .imem_ack(ia), .dmem_ack(da),
        .imem_req(imem_req), .ir_load(ir_load), .dmem_rd_req(dmem_rd_req),
        .dmem_wr_req(dmem_wr_req), .rf_we(rf_we), .pc_write(pc_write),
        .busy(busy), .fault(fault), .state(state), .instr_count(instr_count)
    );

    multicycle_sequencer #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .halt_req(halt_req), .opCode(op),
        .dec_mem_read(rd), .dec_mem_write(wr), .dec_reg_write(rw),
        .imem_ack(ia), .dmem_ack(da),
        .imem_req(imem_req4), .ir_load(ir_load4), .dmem_rd_req(dmem_rd_req4),
        .dmem_wr_req(dmem_wr_req4), .rf_we(rf_we4), .pc_write(pc_write4),
        .busy(busy4), .fault(fault4), .state(state4), .instr_count(instr_count4)
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic st, input logic hr, input logic [4:0] o,
                                input logic r, input logic w, input logic g,
                                input logic i, input logic d,
                                input logic [2:0] es, input logic [7:0] eo, input logic [31:0] ec);
        vec_t v;
        v.st = st; v.hr = hr; v.op = o; v.rd = r; v.wr = w; v.rw = g;
        v.ia = i;  v.da = d;  v.es = es; v.eo = eo; v.ec = ec;
        return v;
    endfunction

    function automatic logic [7:0] flags();
        return {imem_req, ir_load, dmem_rd_req, dmem_wr_req, rf_we, pc_write, busy, fault};
    endfunction

    function automatic logic [7:0] flags4();
        return {imem_req4, ir_load4, dmem_rd_req4, dmem_wr_req4, rf_we4, pc_write4, busy4, fault4};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic check_vec(input vec_t v, input string tag);
        @(negedge clk);
        start = v.st; halt_req = v.hr; op = v.op; rd = v.rd; wr = v.wr; rw = v.rw;
        ia = v.ia; da = v.da;
        #1;
        chk($sformatf("%s_state", tag), 64'(state), 64'(v.es));
        chk($sformatf("%s_flags", tag), 64'(flags()), 64'(v.eo));
        chk($sformatf("%s_count", tag), 64'(instr_count), 64'(v.ec));
        chk($sformatf("%s_dut4", tag), 64'({state4, flags4(), instr_count4}),
            64'({v.es, v.eo, v.ec[3:0]}));
    endtask

    task automatic step(input logic st, input logic hr, input logic [4:0] o,
                        input logic r, input logic w, input logic g,
                        input logic i, input logic d,
                        input logic [2:0] es, input logic [7:0] eo, input logic [31:0] ec,
                        input string tag);
        check_vec(mk(st, hr, o, r, w, g, i, d, es, eo, ec), tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b0; start = 0; halt_req = 0; op = 0; rd = 0; wr = 0; rw = 0; ia = 0; da = 0;
        @(negedge clk);
        #1;
        chk($sformatf("%s_state", tag), 64'(state), 64'(S_IDLE));
        chk($sformatf("%s_flags", tag), 64'(flags()), 64'(O_NONE));
        chk($sformatf("%s_count", tag), 64'(instr_count), 64'd0);
        chk($sformatf("%s_dut4", tag), 64'({state4, flags4(), instr_count4}), 64'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Branch (op 6) from FETCH with immediate ack: 3 cycles, retires in EXEC.
    task automatic branch(input logic [31:0] c, input string tag);
        step(0, 0, 5'd6, 0, 0, 0, 1, 0, S_FETCH,  O_FA,  c, {tag, "_f"});
        step(0, 0, 5'd6, 0, 0, 0, 0, 0, S_DECODE, O_BSY, c, {tag, "_d"});
        step(0, 0, 5'd6, 0, 0, 0, 0, 0, S_EXEC,   O_PCW, c, {tag, "_e"});
    endtask

    vec_t tbl[$];

    initial begin
        rst = 1'b0; start = 0; halt_req = 0; op = 0; rd = 0; wr = 0; rw = 0; ia = 0; da = 0;

        // add, sw with waits, branch, bal, HALT opcode and resume
        tbl.push_back(mk(1, 0,  5'd0, 0, 0, 1, 0, 0, S_IDLE,   O_NONE, 0));
        tbl.push_back(mk(0, 0,  5'd0, 0, 0, 1, 1, 0, S_FETCH,  O_FA,   0));
        tbl.push_back(mk(0, 0,  5'd0, 0, 0, 1, 0, 0, S_DECODE, O_BSY,  0));
        tbl.push_back(mk(0, 0,  5'd0, 0, 0, 1, 0, 0, S_EXEC,   O_BSY,  0));
        tbl.push_back(mk(0, 0,  5'd0, 0, 0, 1, 0, 0, S_WB,     O_WB,   0));
        tbl.push_back(mk(0, 0,  5'd3, 0, 1, 0, 0, 0, S_FETCH,  O_FW,   1));
        tbl.push_back(mk(1, 0,  5'd3, 0, 1, 0, 1, 0, S_FETCH,  O_FA,   1));
        tbl.push_back(mk(0, 0,  5'd3, 0, 1, 0, 0, 0, S_DECODE, O_BSY,  1));
        tbl.push_back(mk(0, 0,  5'd3, 0, 1, 0, 0, 0, S_EXEC,   O_BSY,  1));
        tbl.push_back(mk(0, 0,  5'd3, 0, 1, 0, 0, 0, S_MEM,    O_MWR,  1));
        tbl.push_back(mk(0, 0,  5'd3, 0, 1, 0, 0, 0, S_MEM,    O_MWR,  1));
        tbl.push_back(mk(0, 0,  5'd3, 0, 1, 0, 0, 1, S_MEM,    O_MWRA, 1));
        tbl.push_back(mk(0, 0,  5'd6, 0, 0, 0, 1, 0, S_FETCH,  O_FA,   2));
        tbl.push_back(mk(0, 0,  5'd6, 0, 0, 0, 0, 0, S_DECODE, O_BSY,  2));
        tbl.push_back(mk(0, 0,  5'd6, 0, 0, 0, 0, 0, S_EXEC,   O_PCW,  2));
        tbl.push_back(mk(0, 0,  5'd9, 0, 0, 1, 1, 0, S_FETCH,  O_FA,   3));
        tbl.push_back(mk(0, 0,  5'd9, 0, 0, 1, 0, 0, S_DECODE, O_BSY,  3));
        tbl.push_back(mk(0, 0,  5'd9, 0, 0, 1, 0, 0, S_EXEC,   O_BSY,  3));
        tbl.push_back(mk(0, 0,  5'd9, 0, 0, 1, 0, 0, S_WB,     O_WB,   3));
        tbl.push_back(mk(0, 0, 5'd31, 0, 0, 0, 1, 0, S_FETCH,  O_FA,   4));
        tbl.push_back(mk(0, 0, 5'd31, 0, 0, 0, 0, 0, S_DECODE, O_BSY,  4));
        tbl.push_back(mk(0, 1, 5'd31, 0, 0, 0, 0, 0, S_HALT,   O_NONE, 4));
        tbl.push_back(mk(1, 0, 5'd31, 0, 0, 0, 0, 0, S_HALT,   O_NONE, 4));
        tbl.push_back(mk(0, 0,  5'd2, 1, 0, 1, 0, 0, S_FETCH,  O_FW,   4));

        do_reset("rst0");
        for (int i = 0; i < tbl.size(); i++) check_vec(tbl[i], $sformatf("t%0d", i));

        // lw, dmem_ack after 3 wait cycles: 8 cycles total
        step(0, 0, 5'd2, 1, 0, 1, 1, 0, S_FETCH,  O_FA,  4, "lw_f");
        step(0, 0, 5'd2, 1, 0, 1, 0, 0, S_DECODE, O_BSY, 4, "lw_d");
        step(0, 0, 5'd2, 1, 0, 1, 0, 0, S_EXEC,   O_BSY, 4, "lw_e");
        for (int i = 0; i < 3; i++)
            step(0, 0, 5'd2, 1, 0, 1, 0, 0, S_MEM, O_MRD, 4, $sformatf("lw_m%0d", i));
        step(0, 0, 5'd2, 1, 0, 1, 0, 1, S_MEM,    O_MRD, 4, "lw_ack");
        step(0, 0, 5'd2, 1, 0, 1, 0, 0, S_WB,     O_WB,  4, "lw_wb");

        // halt_req during MEM of lw: retire, then HALT; start resumes
        step(0, 0, 5'd2, 1, 0, 1, 1, 0, S_FETCH,  O_FA,   5, "hl_f");
        step(0, 0, 5'd2, 1, 0, 1, 0, 0, S_DECODE, O_BSY,  5, "hl_d");
        step(0, 0, 5'd2, 1, 0, 1, 0, 0, S_EXEC,   O_BSY,  5, "hl_e");
        step(0, 1, 5'd2, 1, 0, 1, 0, 0, S_MEM,    O_MRD,  5, "hl_m");
        step(0, 1, 5'd2, 1, 0, 1, 0, 1, S_MEM,    O_MRD,  5, "hl_ack");
        step(0, 1, 5'd2, 1, 0, 1, 0, 0, S_WB,     O_WB,   5, "hl_wb");
        step(0, 0, 5'd2, 1, 0, 1, 0, 0, S_HALT,   O_NONE, 6, "hl_halt");
        step(1, 0, 5'd2, 1, 0, 1, 0, 0, S_HALT,   O_NONE, 6, "hl_start");
        branch(6, "hl_br");

        // imem_ack arriving on the cycle the timer expires still proceeds
        for (int i = 0; i < 15; i++)
            step(0, 0, 5'd6, 0, 0, 0, 0, 0, S_FETCH, O_FW, 7, $sformatf("to_w%0d", i));
        branch(7, "to_edge");

        // no imem_ack: FAULT after the wait budget, sticky until reset
        for (int i = 0; i < 16; i++)
            step(0, 0, 5'd6, 0, 0, 0, 0, 0, S_FETCH, O_FW, 8, $sformatf("tf_w%0d", i));
        for (int i = 0; i < 3; i++)
            step(1, 0, 5'd6, 0, 0, 0, 1, 1, S_FAULT, O_FLT, 8, $sformatf("tf_sticky%0d", i));
        do_reset("rst1");

        // decode asks for read and write together -> FAULT
        step(1, 0, 5'd3, 1, 1, 0, 0, 0, S_IDLE,   O_NONE, 0, "rw_i");
        step(0, 0, 5'd3, 1, 1, 0, 1, 0, S_FETCH,  O_FA,   0, "rw_f");
        step(0, 0, 5'd3, 1, 1, 0, 0, 0, S_DECODE, O_BSY,  0, "rw_d");
        step(0, 0, 5'd3, 1, 1, 0, 0, 0, S_EXEC,   O_BSY,  0, "rw_e");
        step(0, 0, 5'd3, 1, 1, 0, 0, 1, S_FAULT,  O_FLT,  0, "rw_flt");
        do_reset("rst2");

        // asynchronous reset in the middle of a MEM wait
        step(1, 0, 5'd6, 0, 0, 0, 0, 0, S_IDLE, O_NONE, 0, "ar_i");
        branch(0, "ar_br");
        step(0, 0, 5'd2, 1, 0, 1, 1, 0, S_FETCH,  O_FA,  1, "ar_f");
        step(0, 0, 5'd2, 1, 0, 1, 0, 0, S_DECODE, O_BSY, 1, "ar_d");
        step(0, 0, 5'd2, 1, 0, 1, 0, 0, S_EXEC,   O_BSY, 1, "ar_e");
        step(0, 0, 5'd2, 1, 0, 1, 0, 0, S_MEM,    O_MRD, 1, "ar_m");
        #1 rst = 1'b0;
        #1;
        chk("ar_async_state", 64'(state), 64'(S_IDLE));
        chk("ar_async_flags", 64'(flags()), 64'(O_NONE));
        chk("ar_async_count", 64'(instr_count), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // 17 branches: 4-bit counter wraps 15 -> 0
        step(1, 0, 5'd6, 0, 0, 0, 0, 0, S_IDLE, O_NONE, 0, "wr_i");
        for (int i = 0; i < 17; i++) branch(32'(i), $sformatf("wr%0d", i));
        step(0, 0, 5'd6, 0, 0, 0, 0, 0, S_FETCH, O_FW, 17, "wr_end");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
